irrigation_encoder: RTL and testbench
=====================================

# irrigation_encoder

Sequential encoder that turns field sensor inputs into the 2-bit irrigation mode code (bit1, bit0) consumed by the seven-segment mode display decoder. It synchronises the raw inputs and applies a persistence filter plus a minimum-dwell timer, so the displayed and actuated mode never chatters. A safety lockout bypasses both timers. It sits between the sensor/switch pins and the display decoder.

## Interface
- STABLE_CYCLES, 4, consecutive edges a new non-lockout candidate must persist before commit (≥1)
- MIN_HOLD, 16, edges a committed mode is held before another non-lockout change is allowed (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock, all state cleared on the edge where reset=1
- moisture  in  2  soil level, async: 00 saturated, 01 moist, 10 dry, 11 very dry
- tank_low  in  1  reservoir below conservation threshold, async
- tank_empty  in  1  reservoir empty, async
- enable  in  1  operator authorisation switch, async
- bit0  out  1  mode code LSB, registered
- bit1  out  1  mode code MSB, registered
- code_change  out  1  one-cycle pulse, high in the first cycle a new code is on bit1/bit0

## Operation
- Codes {bit1,bit0}: IDLE 00 (display blank), SPRINKLER 01 ('A'), DRIP 10 ('G'), NO_AUTH 11 ('-').
- All five async inputs pass through a 2-flop synchroniser; sync flops reset to 0.
- Candidate, combinational from synced values, priority order: tank_empty=1 or enable=0 → NO_AUTH; moisture=11 and tank_low=0 → SPRINKLER; moisture=11 and tank_low=1 → DRIP; moisture=10 → DRIP; else IDLE.
- State machine states IDLE, SPRINKLER, DRIP, LOCKOUT; bit1/bit0 are the registered state encoding.
- Lockout: candidate NO_AUTH while state≠LOCKOUT → LOCKOUT on the next edge, ignoring stability and hold counters.
- Normal transition: candidate ≠ state, candidate ≠ NO_AUTH, candidate identical on STABLE_CYCLES consecutive edges, and hold counter 0 → state := candidate on the STABLE_CYCLES-th edge.
- Stability counter clears whenever the candidate differs from the previous edge's candidate; otherwise it increments, saturating at STABLE_CYCLES-1. It continues counting while hold is active, so commit happens on the first edge after hold expiry if the candidate is still stable.
- Every state change (including entry to LOCKOUT) loads hold counter with MIN_HOLD; it decrements to 0 and stays.
- Leaving LOCKOUT follows the normal rule (stability + hold).
- Candidate equal to current state: no change, no pulse; stability counter state irrelevant.
- code_change registered alongside the state: 1 for exactly the cycle after any state change.

## Timing
- Reset values: bit0=0, bit1=0 (IDLE), code_change=0, counters 0, sync flops 0.
- Synced enable is 0 after reset, so first edge with reset=0 enters LOCKOUT (code 11, code_change=1); earliest normal mode follows after MIN_HOLD edges.
- Raw input → NO_AUTH on outputs: 3 edges (2 sync + 1).
- Raw input → normal mode on outputs: 2 + STABLE_CYCLES edges (6 at defaults) when hold already 0.
- Candidate glitch shorter than STABLE_CYCLES edges: no output change, no pulse.
- Reset asserted mid-hold or mid-count: outputs return to 00 on that edge, all counters cleared.

## Structure
- Package irrigation_pkg: code constants CODE_IDLE, CODE_SPRINKLER, CODE_DRIP, CODE_NO_AUTH; moisture level constants; state encoding equal to code encoding.
- Counter widths derived from parameters via $clog2.
- One sub-module: sync2 (parameterised-width 2-flop synchroniser, synchronous active-high reset), instantiated once for 5 bits.

## Test plan
- Reset, then enable=1, tank_empty=0, moisture=00: code 11 one edge after reset release, code_change pulse; returns to 00 after hold expiry plus stability, second pulse.
- From IDLE (hold 0), moisture 00→11, tank_low=0: code 01 exactly 6 edges after the change, single code_change pulse.
- In SPRINKLER with hold 0, moisture toggles 11→10 for 3 edges then back: code stays 01, no pulse.
- In DRIP just committed, tank_empty=1 at edge 2 of hold: code 11 three edges later despite active hold.
- Commit SPRINKLER, then moisture=10 immediately: code stays 01 for 16 edges, changes to 10 on first edge hold reaches 0.
- Reset asserted mid-hold in DRIP: outputs 00 and code_change=0 on that edge; sequence restarts as in first scenario.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared encodings for the irrigation mode encoder: display codes, moisture
// levels, the state type and the sensor-to-candidate priority rule.
package irrigation_pkg;

   localparam logic [1:0] CODE_IDLE      = 2'b00;
   localparam logic [1:0] CODE_SPRINKLER = 2'b01;
   localparam logic [1:0] CODE_DRIP      = 2'b10;
   localparam logic [1:0] CODE_NO_AUTH   = 2'b11;

   localparam logic [1:0] MOIST_SATURATED = 2'b00;
   localparam logic [1:0] MOIST_MOIST     = 2'b01;
   localparam logic [1:0] MOIST_DRY       = 2'b10;
   localparam logic [1:0] MOIST_VERY_DRY  = 2'b11;

   // State encoding is the display code, so the outputs are the state bits.
   typedef enum logic [1:0] {
      ST_IDLE      = CODE_IDLE,
      ST_SPRINKLER = CODE_SPRINKLER,
      ST_DRIP      = CODE_DRIP,
      ST_LOCKOUT   = CODE_NO_AUTH
   } state_t;

   function automatic logic [1:0] candidate_code(
      input logic [1:0] moisture,
      input logic       tank_low,
      input logic       tank_empty,
      input logic       enable
   );
      logic [1:0] code;
      code = CODE_IDLE;
      if (tank_empty || !enable)
         code = CODE_NO_AUTH;
      else if (moisture == MOIST_VERY_DRY)
         code = tank_low ? CODE_DRIP : CODE_SPRINKLER;
      else if (moisture == MOIST_DRY)
         code = CODE_DRIP;
      return code;
   endfunction

endpackage

// File: rtl/irrigation_encoder_sync2.sv
// Two-flop synchroniser for a bundle of independent asynchronous inputs.
module sync2 #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/irrigation_encoder.sv
// Irrigation mode encoder: synchronised sensor inputs, persistence filter and
// minimum-dwell timer feeding a registered 2-bit mode code; lockout bypasses both.
module irrigation_encoder
   import irrigation_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int MIN_HOLD      = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] moisture,
   input  logic       tank_low,
   input  logic       tank_empty,
   input  logic       enable,
   output logic       bit0,
   output logic       bit1,
   output logic       code_change
);

   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int HW = $clog2(MIN_HOLD + 1);
   localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD);

   logic [4:0]    w_raw;
   logic [4:0]    w_sync;
   logic [1:0]    w_cand;
   logic [SW-1:0] w_stab_next;
   logic          w_stable;
   logic          w_lockout;
   logic          w_normal;

   state_t        r_state;
   logic [1:0]    r_prev_cand;
   logic [SW-1:0] r_stab_cnt;
   logic [HW-1:0] r_hold;
   logic          r_change;

   assign w_raw = {enable, tank_empty, tank_low, moisture};

   sync2 #(.W(5)) u_sync (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (w_raw),
      .o_q     (w_sync)
   );

   assign w_cand = candidate_code(w_sync[1:0], w_sync[2], w_sync[3], w_sync[4]);

   // Counter saturates at STABLE_CYCLES-1, reached on the STABLE_CYCLES-th identical edge.
   always_comb begin
      w_stab_next = '0;
      if (w_cand == r_prev_cand)
         w_stab_next = (r_stab_cnt == STAB_MAX) ? r_stab_cnt : r_stab_cnt + 1'b1;
   end

   assign w_stable  = (w_stab_next == STAB_MAX);
   assign w_lockout = (w_cand == CODE_NO_AUTH) && (r_state != ST_LOCKOUT);
   assign w_normal  = (w_cand != CODE_NO_AUTH) && (w_cand != r_state) &&
                      w_stable && (r_hold == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_prev_cand <= CODE_IDLE;
         r_stab_cnt  <= '0;
         r_hold      <= '0;
         r_change    <= 1'b0;
      end else begin
         r_prev_cand <= w_cand;
         r_stab_cnt  <= w_stab_next;
         r_change    <= 1'b0;
         if (w_lockout || w_normal) begin
            r_state  <= state_t'(w_cand);
            r_hold   <= HOLD_LOAD;
            r_change <= 1'b1;
         end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
         end
      end
   end

   assign bit1        = r_state[1];
   assign bit0        = r_state[0];
   assign code_change = r_change;

endmodule

// File: tb/tb_irrigation_encoder.sv
// Bench for irrigation_encoder: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the sensor-to-mode rules.
module tb_irrigation_encoder;
   import irrigation_pkg::*;

   localparam int S = 4;
   localparam int H = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] moisture = 2'b00;
   logic       tank_low = 1'b0;
   logic       tank_empty = 1'b0;
   logic       enable = 1'b0;
   logic       bit0, bit1, code_change;

   int n_checks = 0;
   int n_pass = 0;

   irrigation_encoder #(.STABLE_CYCLES(S), .MIN_HOLD(H)) dut (
      .clk         (clk),
      .reset       (reset),
      .moisture    (moisture),
      .tank_low    (tank_low),
      .tank_empty  (tank_empty),
      .enable      (enable),
      .bit0        (bit0),
      .bit1        (bit1),
      .code_change (code_change)
   );

   always #5 clk = ~clk;

   // Reference model: two-stage delay of raw inputs, candidate history, last-change edge.
   logic [4:0] m_s1 = '0, m_s2 = '0;
   logic [1:0] m_state = CODE_IDLE;
   logic       m_pulse = 1'b0;
   logic [1:0] m_hist[$];
   int         m_edge = 0;
   int         m_last = -100000;

   function automatic logic [1:0] ref_cand(input logic [4:0] s);
      logic en, empty, low;
      logic [1:0] m;
      en = s[4]; empty = s[3]; low = s[2]; m = s[1:0];
      if (empty == 1'b1 || en == 1'b0) return CODE_NO_AUTH;
      if (m == 2'b11 && low == 1'b0) return CODE_SPRINKLER;
      if (m == 2'b11 && low == 1'b1) return CODE_DRIP;
      if (m == 2'b10) return CODE_DRIP;
      return CODE_IDLE;
   endfunction

   task automatic tick();
      logic [4:0] raw;
      logic [1:0] c;
      logic stable, chg;
      @(posedge clk);
      raw = {enable, tank_empty, tank_low, moisture};
      if (reset) begin
         m_s1 = '0; m_s2 = '0;
         m_state = CODE_IDLE; m_pulse = 1'b0;
         m_hist.delete();
         m_last = m_edge - 100000;
      end else begin
         m_edge++;
         c = ref_cand(m_s2);
         m_hist.push_back(c);
         if (m_hist.size() > S) void'(m_hist.pop_front());
         stable = (m_hist.size() == S);
         foreach (m_hist[i]) if (m_hist[i] != c) stable = 1'b0;
         chg = 1'b0;
         if (c == CODE_NO_AUTH && m_state != CODE_NO_AUTH) chg = 1'b1;
         else if (c != CODE_NO_AUTH && c != m_state && stable && (m_edge - m_last) > H) chg = 1'b1;
         if (chg) begin
            m_state = c;
            m_last = m_edge;
         end
         m_pulse = chg;
         m_s2 = m_s1;
         m_s1 = raw;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({bit1, bit0, code_change} !== 3'b000)
         $display("FAIL reset: got code=%b%b pulse=%b, want code=00 pulse=0", bit1, bit0, code_change);
      else n_pass++;
   endtask

   // Expects reset asserted on entry; releases it and checks lockout then return to idle.
   task automatic test_startup();
      logic [1:0] exp_code;
      logic       exp_pulse;
      enable = 1'b1; tank_empty = 1'b0; tank_low = 1'b0; moisture = 2'b00;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= H + 2; k++) begin
         tick();
         exp_code  = (k < H + 2) ? CODE_NO_AUTH : CODE_IDLE;
         exp_pulse = (k == 1) || (k == H + 2);
         n_checks++;
         if ({bit1, bit0, code_change} !== {exp_code, exp_pulse})
            $display("FAIL startup edge %0d: got code=%b%b pulse=%b, want code=%b pulse=%b",
                     k, bit1, bit0, code_change, exp_code, exp_pulse);
         else n_pass++;
      end
   endtask

   task automatic test_sprinkler();
      logic [1:0] exp_code;
      for (int k = 0; k < H + 4; k++) tick();
      moisture = 2'b11; tank_low = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_code = (k >= 2 + S) ? CODE_SPRINKLER : CODE_IDLE;
         n_checks++;
         if ({bit1, bit0, code_change} !== {exp_code, 1'(k == 2 + S)})
            $display("FAIL sprinkler edge %0d: got code=%b%b pulse=%b, want code=%b pulse=%b",
                     k, bit1, bit0, code_change, exp_code, (k == 2 + S));
         else n_pass++;
      end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < H + 4; k++) tick();
      moisture = 2'b10;
      for (int k = 1; k <= 12; k++) begin
         if (k == 4) moisture = 2'b11;
         tick();
         n_checks++;
         if ({bit1, bit0, code_change} !== {CODE_SPRINKLER, 1'b0})
            $display("FAIL glitch edge %0d: got code=%b%b pulse=%b, want code=01 pulse=0",
                     k, bit1, bit0, code_change);
         else n_pass++;
      end
   endtask

   task automatic test_lockout_in_hold();
      int cnt;
      logic [1:0] exp_code;
      moisture = 2'b10;
      cnt = 0;
      while ({bit1, bit0} !== CODE_DRIP && cnt < 12) begin
         tick();
         cnt++;
      end
      n_checks++;
      if (cnt != 2 + S || code_change !== 1'b1)
         $display("FAIL drip_commit: got %0d edges pulse=%b, want %0d edges pulse=1", cnt, code_change, 2 + S);
      else n_pass++;
      tick();
      tank_empty = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         exp_code = (k == 3) ? CODE_NO_AUTH : CODE_DRIP;
         n_checks++;
         if ({bit1, bit0, code_change} !== {exp_code, 1'(k == 3)})
            $display("FAIL lockout_in_hold edge %0d: got code=%b%b pulse=%b, want code=%b pulse=%b",
                     k, bit1, bit0, code_change, exp_code, (k == 3));
         else n_pass++;
      end
   endtask

   task automatic test_hold_after_commit();
      int cnt;
      logic [1:0] exp_code;
      tank_empty = 1'b0; tank_low = 1'b0; moisture = 2'b11;
      cnt = 0;
      while ({bit1, bit0} !== CODE_SPRINKLER && cnt < 40) begin
         tick();
         cnt++;
      end
      n_checks++;
      if (cnt != H + 1 || code_change !== 1'b1)
         $display("FAIL lockout_exit: got %0d edges pulse=%b, want %0d edges pulse=1", cnt, code_change, H + 1);
      else n_pass++;
      moisture = 2'b10;
      for (int k = 1; k <= H + 1; k++) begin
         tick();
         exp_code = (k <= H) ? CODE_SPRINKLER : CODE_DRIP;
         n_checks++;
         if ({bit1, bit0, code_change} !== {exp_code, 1'(k == H + 1)})
            $display("FAIL hold edge %0d: got code=%b%b pulse=%b, want code=%b pulse=%b",
                     k, bit1, bit0, code_change, exp_code, (k == H + 1));
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_hold();
      tick();
      tick();
      tick();
      reset = 1'b1;
      enable = 1'b1; tank_empty = 1'b0; moisture = 2'b00;
      tick();
      n_checks++;
      if ({bit1, bit0, code_change} !== 3'b000)
         $display("FAIL reset_mid_hold: got code=%b%b pulse=%b, want code=00 pulse=0", bit1, bit0, code_change);
      else n_pass++;
      test_startup();
   endtask

   task automatic test_random();
      int dur;
      int errs;
      errs = 0;
      reset = 1'b0;
      for (int n = 0; n < 300; n++) begin
         enable     = ($urandom_range(0, 15) != 0);
         tank_empty = ($urandom_range(0, 15) == 0);
         tank_low   = 1'($urandom_range(0, 1));
         moisture   = 2'($urandom_range(0, 3));
         dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 24);
         for (int k = 0; k < dur; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++;
            if ({bit1, bit0, code_change} !== {m_state, m_pulse}) begin
               errs++;
               if (errs <= 10)
                  $display("FAIL random step %0d: got code=%b%b pulse=%b, want code=%b pulse=%b",
                           n, bit1, bit0, code_change, m_state, m_pulse);
            end else n_pass++;
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_sprinkler();
      test_glitch();
      test_lockout_in_hold();
      test_hold_after_commit();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
